// File: rtl/lut_index_gen_pkg.sv
// Shared definitions for the LUT index generator and the LookupTable
// instances it feeds.
//   state_t    : sequencer state encoding (2 bits)
//   LUT_ADDR_W : default LUT index width
//   LUT_DATA_W : default LUT data width
package lut_index_gen_pkg;

    localparam int LUT_ADDR_W = 8;
    localparam int LUT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lut_idx_counter.sv
// Wrapping up-counter with synchronous load, enable and terminal count.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load count with load_val (has priority over en)
//   load_val  : value loaded on load
//   en        : advance count; wraps to 0 after reaching last
//   last      : terminal value of the count
//   tc        : count == last
module lut_idx_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    assign tc = (count == last);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/lut_index_gen.sv
// 2-D index stream generator feeding the LookupTable read ports.
// Emits base + j*incr for j in [0, period), base stepping by shift for
// each of `iterations` rows, after `delay` idle cycles.
//   clk, rst   : clock, synchronous active-high reset
//   run        : start pulse, honoured only in IDLE/DONE
//   start..offset : static configuration, latched on an accepted run
//   out0/out1  : index and index+offset, zero-extended to DATA_W
//   valid      : out0/out1 carry a live index
//   done       : high while idle
//
// state | meaning
// IDLE  | after reset, waiting for run
// DELAY | counting delay cycles before the first index
// RUN   | emitting one index per cycle; one extra cycle to retire
// DONE  | stream finished (or zero-length), waiting for run
module lut_index_gen
    import lut_index_gen_pkg::*;
#(
    parameter int DATA_W = LUT_DATA_W,
    parameter int ADDR_W = LUT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] start,
    input  logic [ADDR_W-1:0] incr,
    input  logic [ADDR_W-1:0] period,
    input  logic [ADDR_W-1:0] iterations,
    input  logic [ADDR_W-1:0] shift,
    input  logic [ADDR_W-1:0] delay,
    input  logic [ADDR_W-1:0] offset,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic              valid,
    output logic              done
);

    state_t            state;
    logic [ADDR_W-1:0] incr_q, period_q, iter_q, shift_q, delay_q, offset_q;
    logic [ADDR_W-1:0] idx, base, out0_q, out1_q;
    logic              valid_q, done_q;
    // Set once the final index is registered; RUN then spends one more
    // cycle so valid drops and done rises together on the next edge.
    logic              fin;

    logic accept, emit;
    logic dly_tc, j_tc, i_tc;

    assign accept = run && ((state == ST_IDLE) || (state == ST_DONE));
    assign emit   = (state == ST_RUN) && !fin;

    lut_idx_counter #(.W(ADDR_W)) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ('0),
        .en       (state == ST_DELAY),
        .last     (delay_q - ADDR_W'(1)),
        .tc       (dly_tc)
    );

    lut_idx_counter #(.W(ADDR_W)) u_j_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ('0),
        .en       (emit),
        .last     (period_q - ADDR_W'(1)),
        .tc       (j_tc)
    );

    lut_idx_counter #(.W(ADDR_W)) u_i_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ('0),
        .en       (emit && j_tc),
        .last     (iter_q - ADDR_W'(1)),
        .tc       (i_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            incr_q   <= '0;
            period_q <= '0;
            iter_q   <= '0;
            shift_q  <= '0;
            delay_q  <= '0;
            offset_q <= '0;
            idx      <= '0;
            base     <= '0;
            out0_q   <= '0;
            out1_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b1;
            fin      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    valid_q <= 1'b0;
                    if (run) begin
                        incr_q   <= incr;
                        period_q <= period;
                        iter_q   <= iterations;
                        shift_q  <= shift;
                        delay_q  <= delay;
                        offset_q <= offset;
                        idx      <= start;
                        base     <= start;
                        fin      <= 1'b0;
                        if ((period == '0) || (iterations == '0)) begin
                            state <= ST_DONE;
                        end else begin
                            done_q <= 1'b0;
                            state  <= (delay != '0) ? ST_DELAY : ST_RUN;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_tc) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (fin) begin
                        state   <= ST_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        out0_q  <= idx;
                        out1_q  <= idx + offset_q;
                        valid_q <= 1'b1;
                        if (j_tc) begin
                            base <= base + shift_q;
                            idx  <= base + shift_q;
                            if (i_tc) fin <= 1'b1;
                        end else begin
                            idx <= idx + incr_q;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out0  = DATA_W'(out0_q);
    assign out1  = DATA_W'(out1_q);
    assign valid = valid_q;
    assign done  = done_q;

endmodule
